// File: rtl/iir_pkg.sv
// iir_pkg: shared widths, quantisation helper and FSM state type for the multi-channel IIR core.
package iir_pkg;
    localparam int DATA_SIZE = 32;
    localparam int BITS = 10;
    localparam int QUANT_VAL = 1 << BITS;
    localparam int PW = 2 * DATA_SIZE;

    typedef enum logic [1:0] {S_READ, S_MAC, S_WRITE} state_t;

    // Divide by QUANT_VAL rounding toward zero: bias negatives before the arithmetic shift.
    function automatic logic signed [DATA_SIZE-1:0] dequantize(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] q;
        q = (p + (p[PW-1] ? PW'(QUANT_VAL - 1) : '0)) >>> BITS;
        return q[DATA_SIZE-1:0];
    endfunction
endpackage

// File: rtl/iir_mc_hist.sv
// iir_mc_hist: per-channel sample history bank with shift-insert at index 0, tap read and global clear.
module iir_mc_hist
    import iir_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int DEPTH = 2,
    parameter int CW = 1,
    parameter int IW = 1
)(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        shift,
    input  logic [CW-1:0]               ch,
    input  logic signed [DATA_SIZE-1:0] din,
    input  logic [IW-1:0]               idx,
    output logic signed [DATA_SIZE-1:0] dout
);
    logic signed [DATA_SIZE-1:0] h [NUM_CHANNELS][DEPTH];

    assign dout = h[ch][idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset || clear) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
                for (int i = 0; i < DEPTH; i++)
                    h[c][i] <= '0;
        end else if (shift) begin
            for (int i = DEPTH - 1; i > 0; i--)
                h[ch][i] <= h[ch][i-1];
            h[ch][0] <= din;
        end
    end
endmodule

// File: rtl/iir_mc.sv
// iir_mc: time-multiplexed multi-channel fixed-point IIR filter between an upstream FWFT FIFO and a downstream FIFO.
module iir_mc
    import iir_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int NUM_TAPS = 2,
    parameter logic signed [DATA_SIZE-1:0] IIR_X_COEFFS [NUM_TAPS] = '{178, 178},
    parameter logic signed [DATA_SIZE-1:0] IIR_Y_COEFFS [NUM_TAPS] = '{0, -666},
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1,
    localparam int KW = $clog2(NUM_TAPS)
)(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_empty,
    output logic                 in_rd_en,
    input  logic [DATA_SIZE-1:0] in_dout,
    input  logic                 out_full,
    output logic                 out_wr_en,
    output logic [DATA_SIZE-1:0] out_din,
    output logic [CW-1:0]        out_chan,
    input  logic                 bypass,
    input  logic                 clear
);
    state_t                      state;
    logic [CW-1:0]               ch;
    logic [KW-1:0]               k, yk;
    logic signed [DATA_SIZE-1:0] acc, cur, x_rd, y_rd, term;
    logic signed [PW-1:0]        px, py;
    logic                        byp, hist_clr;

    // Handshakes are combinational so the popped word is captured on the same edge as the pop.
    assign in_rd_en  = reset && state == S_READ && !clear && !in_empty;
    assign out_wr_en = state == S_WRITE && !out_full;
    assign hist_clr  = state == S_READ && clear;

    // y history stores y[n-1] at bank index 0; k=0 has no feedback term.
    assign yk   = k == '0 ? '0 : k - KW'(1);
    assign px   = PW'(IIR_X_COEFFS[k]) * PW'(x_rd);
    assign py   = PW'(IIR_Y_COEFFS[k]) * PW'(y_rd);
    assign term = dequantize(px) + (k != '0 ? dequantize(py) : '0);

    iir_mc_hist #(.NUM_CHANNELS(NUM_CHANNELS), .DEPTH(NUM_TAPS), .CW(CW), .IW(KW)) u_x_hist (
        .clock(clock), .reset(reset), .clear(hist_clr), .shift(in_rd_en), .ch(ch),
        .din(in_dout), .idx(k), .dout(x_rd)
    );

    iir_mc_hist #(.NUM_CHANNELS(NUM_CHANNELS), .DEPTH(NUM_TAPS - 1), .CW(CW), .IW(KW)) u_y_hist (
        .clock(clock), .reset(reset), .clear(hist_clr), .shift(out_wr_en), .ch(ch),
        .din(out_din), .idx(yk), .dout(y_rd)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_READ;
            ch       <= '0;
            k        <= '0;
            acc      <= '0;
            cur      <= '0;
            byp      <= 1'b0;
            out_din  <= '0;
            out_chan <= '0;
        end else begin
            case (state)
                S_READ: begin
                    if (clear) begin
                        ch <= '0;
                    end else if (!in_empty) begin
                        cur   <= in_dout;
                        byp   <= bypass;
                        acc   <= '0;
                        k     <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + term;
                    if (k == KW'(NUM_TAPS - 1)) begin
                        out_din  <= byp ? cur : acc + term;
                        out_chan <= ch;
                        state    <= S_WRITE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                S_WRITE: begin
                    if (!out_full) begin
                        ch    <= ch == CW'(NUM_CHANNELS - 1) ? '0 : ch + CW'(1);
                        state <= S_READ;
                    end
                end
                default: state <= S_READ;
            endcase
        end
    end
endmodule

// File: tb/tb_iir_mc.sv
// tb_iir_mc: table-driven directed test of iir_mc with hand-computed responses and stall/clear/reset sequences.
module tb_iir_mc;
    typedef struct {
        int x;
        bit byp;
        int exp;
        int chan;
    } vec_t;

    logic        clock = 0, reset = 0, out_full = 0, clear = 0;
    logic        in_empty, in_rd_en, out_wr_en, bypass, out_chan;
    logic [31:0] in_dout, out_din;

    int in_mem [64];
    bit in_bm [64];
    int in_wr = 0, in_rd = 0;
    int out_d [64];
    int out_c [64];
    int out_n = 0;
    int checks = 0, errors = 0, overlap_n = 0;
    vec_t tab [23];

    assign in_empty = in_rd == in_wr;
    assign in_dout  = in_mem[in_rd];
    assign bypass   = in_bm[in_rd];

    iir_mc dut (
        .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(in_rd_en), .in_dout(in_dout),
        .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din), .out_chan(out_chan),
        .bypass(bypass), .clear(clear)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (in_rd_en) in_rd <= in_rd + 1;
        if (out_wr_en) begin
            out_d[out_n] <= int'(out_din);
            out_c[out_n] <= int'(out_chan);
            out_n <= out_n + 1;
        end
    end

    always @(negedge clock)
        if (in_rd_en && out_wr_en) overlap_n <= overlap_n + 1;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(int x, bit b);
        in_mem[in_wr] = x;
        in_bm[in_wr] = b;
        in_wr++;
    endtask

    task automatic wait_outs(int target);
        int t = 0;
        while (out_n < target && t < 300) begin
            @(negedge clock);
            t++;
        end
        check("outputs_arrived", out_n, target);
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear = 1;
        @(negedge clock);
        clear = 0;
    endtask

    task automatic run_phase(string name, int s, int n);
        int base;
        pulse_clear();
        base = out_n;
        for (int i = 0; i < n; i++) push(tab[s+i].x, tab[s+i].byp);
        wait_outs(base + n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_din%0d", name, i), out_d[base+i], tab[s+i].exp);
            check($sformatf("%s_chan%0d", name, i), out_c[base+i], tab[s+i].chan);
        end
    endtask

    initial begin
        int base, ib, bad, d, t;
        // impulse on ch0, silence on ch1
        tab[0]  = '{1024, 1'b0, 178, 0};  tab[1]  = '{0, 1'b0, 0, 1};
        tab[2]  = '{0, 1'b0, 63, 0};      tab[3]  = '{0, 1'b0, 0, 1};
        tab[4]  = '{0, 1'b0, -40, 0};     tab[5]  = '{0, 1'b0, 0, 1};
        // impulse on both channels
        tab[6]  = '{1024, 1'b0, 178, 0};  tab[7]  = '{1024, 1'b0, 178, 1};
        tab[8]  = '{0, 1'b0, 63, 0};      tab[9]  = '{0, 1'b0, 63, 1};
        tab[10] = '{0, 1'b0, -40, 0};     tab[11] = '{0, 1'b0, -40, 1};
        // bypass on third ch0 sample feeds back as y[n-1]
        tab[12] = '{1024, 1'b0, 178, 0};  tab[13] = '{0, 1'b0, 0, 1};
        tab[14] = '{0, 1'b0, 63, 0};      tab[15] = '{0, 1'b0, 0, 1};
        tab[16] = '{500, 1'b1, 500, 0};   tab[17] = '{0, 1'b0, 0, 1};
        tab[18] = '{0, 1'b0, -239, 0};
        // y[n-1]=178 makes the feedback term -118548/1024 -> -115
        tab[19] = '{178, 1'b1, 178, 0};   tab[20] = '{0, 1'b0, 0, 1};
        tab[21] = '{0, 1'b0, -85, 0};     tab[22] = '{0, 1'b0, 0, 1};

        repeat (3) @(negedge clock);
        check("rst_din", int'(out_din), 0);
        check("rst_chan", int'(out_chan), 0);
        check("rst_rd_en", int'(in_rd_en), 0);
        check("rst_wr_en", int'(out_wr_en), 0);
        reset = 1;

        run_phase("impulse", 0, 6);
        run_phase("interleave", 6, 6);
        run_phase("bypass", 12, 7);
        run_phase("trunc", 19, 4);

        pulse_clear();
        base = out_n;
        ib = in_rd;
        for (int i = 0; i < 6; i++) push(tab[i].x, tab[i].byp);
        wait_outs(base + 2);
        out_full = 1;
        repeat (5) @(negedge clock);
        check("stall_din", int'(out_din), 63);
        check("stall_pops", in_rd, ib + 3);
        bad = 0;
        d = int'(out_din);
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (int'(out_din) != d || in_rd != ib + 3 || out_wr_en) bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_no_push", out_n, base + 2);
        out_full = 0;
        wait_outs(base + 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("stall_din%0d", i), out_d[base+i], tab[i].exp);
            check($sformatf("stall_chan%0d", i), out_c[base+i], tab[i].chan);
        end

        pulse_clear();
        base = out_n;
        ib = in_rd;
        push(1024, 1'b0);
        push(1024, 1'b0);
        t = 0;
        while (in_rd < ib + 2 && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("mid_pop_seen", in_rd, ib + 2);
        check("mid_pre_din", int'(out_din), 178);
        reset = 0;
        #1;
        check("mid_rst_din", int'(out_din), 0);
        check("mid_rst_chan", int'(out_chan), 0);
        check("mid_rst_wr_en", int'(out_wr_en), 0);
        check("mid_rst_rd_en", int'(in_rd_en), 0);
        repeat (2) @(negedge clock);
        reset = 1;
        repeat (6) @(negedge clock);
        check("mid_discarded", out_n, base + 1);
        push(1024, 1'b0);
        wait_outs(base + 2);
        check("restart_din", out_d[base+1], 178);
        check("restart_chan", out_c[base+1], 0);

        check("no_overlap", overlap_n, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
